// File: rtl/hdlc_tx_pkg.sv
// Shared types and constants for the HDLC transmit channel.
// Holds the framer state encoding, the flag and abort patterns and the serial CRC-16 step.
package hdlc_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FLAG_OPEN  = 3'd1,
    ST_DATA       = 3'd2,
    ST_FCS        = 3'd3,
    ST_FLAG_CLOSE = 3'd4,
    ST_ABORT      = 3'd5
  } tx_state_t;

  localparam logic [7:0]  FLAG          = 8'h7E;
  localparam logic [7:0]  ABORT         = 8'hFE;
  localparam logic [15:0] CRC_POLY      = 16'h8005;
  localparam int          STUFF_LIMIT   = 5;
  localparam int          MAX_BYTES_DEF = 126;

  // One bit of CRC-16 (x^16+x^15+x^2+1), bits fed in transmit order.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic feedback;
    feedback = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/hdlc_tx_fcs.sv
// Serial CRC-16 engine for the transmit channel.
// Cleared between frames and advanced once per unstuffed payload bit.
module hdlc_tx_fcs
  import hdlc_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Next CRC value: clear wins over a shift.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = 16'h0000;
    end else if (enable) begin
      crc_d = crc16_step(crc_q, bit_in);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, LSB-first payload, optional FCS-16, zero insertion,
// idle-ones and abort sequences, with a one-byte prefetch from the Tx buffer.
module hdlc_tx_framer
  import hdlc_tx_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF,
  parameter bit FCS_EN    = 1'b1
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_AbortFrame,
  input  logic [7:0] Tx_FrameSize,
  input  logic [7:0] Tx_Data,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans
);

  localparam logic [7:0] MAX_B   = 8'(MAX_BYTES);
  localparam logic [2:0] STUFF_N = 3'(STUFF_LIMIT);

  tx_state_t   state_q,      state_d;
  logic [3:0]  bit_q,        bit_d;
  logic [2:0]  ones_q,       ones_d;
  logic [7:0]  byte_cnt_q,   byte_cnt_d;
  logic [7:0]  rd_cnt_q,     rd_cnt_d;
  logic [7:0]  size_q,       size_d;
  logic [7:0]  hold_q,       hold_d;
  logic [7:0]  shift_q,      shift_d;
  logic        tx_q,         tx_d;
  logic        valid_q,      valid_d;
  logic        rd_q,         rd_d;
  logic        last_q,       last_d;
  logic        done_q,       done_d;
  logic        aborted_q,    aborted_d;
  logic        abort_prev_q, abort_prev_d;
  logic        abort_pend_q, abort_pend_d;

  logic        abort_rise_s;
  logic        in_frame_s;
  logic        stuff_s;
  logic        crc_clr_s;
  logic        crc_en_s;
  logic        crc_bit_s;
  logic [15:0] crc_s;

  assign abort_rise_s = Tx_AbortFrame & ~abort_prev_q;
  assign in_frame_s   = (state_q == ST_FLAG_OPEN) || (state_q == ST_DATA) || (state_q == ST_FCS);
  assign stuff_s      = (ones_q == STUFF_N);

  hdlc_tx_fcs u_fcs (
    .clk    (Clk),
    .rst    (Rst),
    .clear  (crc_clr_s),
    .enable (crc_en_s),
    .bit_in (crc_bit_s),
    .crc    (crc_s)
  );

  // Next-state, next-bit and strobe logic for the framer.
  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    ones_d       = ones_q;
    byte_cnt_d   = byte_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    size_d       = size_q;
    shift_d      = shift_q;
    hold_d       = rd_q ? Tx_Data : hold_q;
    tx_d         = 1'b1;
    valid_d      = 1'b0;
    rd_d         = 1'b0;
    last_d       = 1'b0;
    done_d       = last_q;
    aborted_d    = 1'b0;
    abort_prev_d = Tx_AbortFrame;
    abort_pend_d = 1'b0;
    crc_clr_s    = 1'b0;
    crc_en_s     = 1'b0;
    crc_bit_s    = 1'b0;

    if (abort_pend_q) begin
      // Accepted abort: freeze the line for one cycle while entering ABORT.
      state_d   = ST_ABORT;
      bit_d     = 4'd0;
      aborted_d = 1'b1;
      tx_d      = tx_q;
      valid_d   = 1'b1;
    end else begin
      abort_pend_d = abort_rise_s & in_frame_s;
      case (state_q)
        ST_IDLE: begin
          crc_clr_s  = 1'b1;
          ones_d     = 3'd0;
          bit_d      = 4'd0;
          byte_cnt_d = 8'd0;
          rd_cnt_d   = 8'd0;
          if (Tx_Enable && (Tx_FrameSize != 8'd0) && !abort_rise_s) begin
            state_d = ST_FLAG_OPEN;
            size_d  = (Tx_FrameSize > MAX_B) ? MAX_B : Tx_FrameSize;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_FLAG_OPEN: begin
          tx_d    = FLAG[bit_q[2:0]];
          valid_d = 1'b1;
          ones_d  = 3'd0;
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd0) begin
            rd_d     = 1'b1;
            rd_cnt_d = rd_cnt_q + 8'd1;
          end else if (bit_q == 4'd7) begin
            state_d = ST_DATA;
            bit_d   = 4'd0;
            shift_d = hold_q;
            if (rd_cnt_q < size_q) begin
              rd_d     = 1'b1;
              rd_cnt_d = rd_cnt_q + 8'd1;
            end else begin
              rd_d = 1'b0;
            end
          end else begin
            rd_d = 1'b0;
          end
        end

        ST_DATA: begin
          valid_d = 1'b1;
          if (stuff_s) begin
            tx_d   = 1'b0;
            ones_d = 3'd0;
          end else begin
            tx_d      = shift_q[bit_q[2:0]];
            crc_en_s  = 1'b1;
            crc_bit_s = tx_d;
            ones_d    = tx_d ? (ones_q + 3'd1) : 3'd0;
            bit_d     = bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              bit_d      = 4'd0;
              byte_cnt_d = byte_cnt_q + 8'd1;
              if ((byte_cnt_q + 8'd1) == size_q) begin
                state_d = FCS_EN ? ST_FCS : ST_FLAG_CLOSE;
              end else begin
                // Byte boundary: next byte comes from the hold register, refill it.
                shift_d = hold_q;
                if (rd_cnt_q < size_q) begin
                  rd_d     = 1'b1;
                  rd_cnt_d = rd_cnt_q + 8'd1;
                end else begin
                  rd_d = 1'b0;
                end
              end
            end else begin
              byte_cnt_d = byte_cnt_q;
            end
          end
        end

        ST_FCS: begin
          valid_d = 1'b1;
          if (stuff_s) begin
            tx_d   = 1'b0;
            ones_d = 3'd0;
          end else begin
            tx_d   = crc_s[bit_q];
            ones_d = tx_d ? (ones_q + 3'd1) : 3'd0;
            bit_d  = bit_q + 4'd1;
            if (bit_q == 4'd15) begin
              state_d = ST_FLAG_CLOSE;
              bit_d   = 4'd0;
            end else begin
              state_d = ST_FCS;
            end
          end
        end

        ST_FLAG_CLOSE: begin
          valid_d = 1'b1;
          ones_d  = 3'd0;
          if (stuff_s) begin
            // Five ones ended the payload/FCS: the stuffed zero still precedes the flag.
            tx_d = 1'b0;
          end else begin
            tx_d  = FLAG[bit_q[2:0]];
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              state_d = ST_IDLE;
              bit_d   = 4'd0;
              last_d  = 1'b1;
            end else begin
              state_d = ST_FLAG_CLOSE;
            end
          end
        end

        ST_ABORT: begin
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd0) begin
            tx_d    = tx_q;
            valid_d = 1'b1;
          end else begin
            tx_d    = ABORT[3'(bit_q - 4'd1)];
            valid_d = 1'b0;
          end
          if (bit_q == 4'd8) begin
            state_d = ST_IDLE;
            bit_d   = 4'd0;
          end else begin
            state_d = ST_ABORT;
          end
        end

        default: begin
          state_d = ST_IDLE;
          bit_d   = 4'd0;
        end
      endcase
    end
  end

  // Framer state and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      bit_q        <= 4'd0;
      ones_q       <= 3'd0;
      byte_cnt_q   <= 8'd0;
      rd_cnt_q     <= 8'd0;
      size_q       <= 8'd0;
      hold_q       <= 8'd0;
      shift_q      <= 8'd0;
      tx_q         <= 1'b1;
      valid_q      <= 1'b0;
      rd_q         <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_prev_q <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      ones_q       <= ones_d;
      byte_cnt_q   <= byte_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      size_q       <= size_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      valid_q      <= valid_d;
      rd_q         <= rd_d;
      last_q       <= last_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_prev_q <= abort_prev_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign Tx              = tx_q;
  assign Tx_ValidFrame   = valid_q;
  assign Tx_RdBuff       = rd_q;
  assign Tx_Done         = done_q;
  assign Tx_AbortedTrans = aborted_q;

endmodule
